y86_pipe_regfile: RTL

- Parametrised register file for the pipelined Y86 core; successor to the sequential decode/writeback register file.
- Provides two combinational read ports (srcA/srcB → valA/valB) for decode and two clocked write ports (E, M) for writeback.
- Adds optional write-through bypass, a per-register pending-write scoreboard with stall generation, a debug read port and synchronous reset.

---
 rtl/y86_pipe_regfile.sv | 126 ++++++++++++
 1 files changed

// File: rtl/y86_pipe_regfile.sv
// y86_pipe_regfile
// Register file for the pipelined Y86 core.
//   - Two combinational read ports (srcA/srcB -> valA/valB), with optional
//     same-cycle forwarding of the writeback data (M has priority over E).
//   - Two clocked write ports (dstE/valE, dstM/valM); M wins when both
//     target the same register. RNONE is never written and always reads 0.
//   - Per-register pending-write scoreboard: issue_valid/issue_dstE/issue_dstM
//     increment, writebacks decrement. hazard_a/hazard_b/stall flag reads of
//     registers with writes still in flight; sb_error is a sticky
//     overflow/underflow flag.
//   - Debug port dbg_addr -> dbg_data reads the array only (no forwarding).
//   - rst: synchronous, active-high; overrides writes and issues.
module y86_pipe_regfile #(
  parameter int DATA_W    = 64,
  parameter int NREGS     = 16,
  parameter int RNONE     = 15,
  parameter int INIT_MODE = 1,
  parameter int BYPASS    = 1,
  parameter int PEND_W    = 2,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     srcA,
  input  logic [AW-1:0]     srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [AW-1:0]     dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [AW-1:0]     dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_dstE,
  input  logic [AW-1:0]     issue_dstM,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              stall,
  output logic              sb_error,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [AW-1:0]     LP_RNONE = AW'(RNONE);
  localparam logic [PEND_W-1:0] LP_CMAX  = '1;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [PEND_W-1:0] r_cnt  [NREGS];
  logic              r_err;

  logic w_wr_a;
  logic w_wr_b;

  // srcX is compared against the write addresses only when srcX != RNONE,
  // so a match here always means a real write to srcX.
  assign w_wr_a = (dstE == srcA) || (dstM == srcA);
  assign w_wr_b = (dstE == srcB) || (dstM == srcB);

  always_comb begin
    valA = '0;
    if (srcA != LP_RNONE) begin
      if (BYPASS == 1 && dstM == srcA)      valA = valM;
      else if (BYPASS == 1 && dstE == srcA) valA = valE;
      else                                  valA = r_regs[srcA];
    end
  end

  always_comb begin
    valB = '0;
    if (srcB != LP_RNONE) begin
      if (BYPASS == 1 && dstM == srcB)      valB = valM;
      else if (BYPASS == 1 && dstE == srcB) valB = valE;
      else                                  valB = r_regs[srcB];
    end
  end

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    if (srcA != LP_RNONE && r_cnt[srcA] != '0)
      hazard_a = !(BYPASS == 1 && r_cnt[srcA] == PEND_W'(1) && w_wr_a);
    if (srcB != LP_RNONE && r_cnt[srcB] != '0)
      hazard_b = !(BYPASS == 1 && r_cnt[srcB] == PEND_W'(1) && w_wr_b);
  end

  assign stall    = hazard_a | hazard_b;
  assign sb_error = r_err;
  assign dbg_data = (dbg_addr == LP_RNONE) ? '0 : r_regs[dbg_addr];

  // Register array; the M write is placed last so it wins on dstE == dstM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        r_regs[i] <= (INIT_MODE == 1) ? DATA_W'(i) : '0;
    end else begin
      if (dstE != LP_RNONE) r_regs[dstE] <= valE;
      if (dstM != LP_RNONE) r_regs[dstM] <= valM;
    end
  end

  // Scoreboard: each register sees at most one increment and one decrement
  // per cycle (duplicate dstE/dstM collapse); a coincident pair cancels.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        r_cnt[i] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        logic [AW-1:0] a;
        logic          inc;
        logic          dec;
        a   = AW'(i);
        inc = issue_valid && (issue_dstE == a || issue_dstM == a) && (a != LP_RNONE);
        dec = (dstE == a || dstM == a) && (a != LP_RNONE);
        if (inc && !dec) begin
          if (r_cnt[i] == LP_CMAX) r_err <= 1'b1;
          else                     r_cnt[i] <= r_cnt[i] + PEND_W'(1);
        end else if (dec && !inc) begin
          if (r_cnt[i] == '0) r_err <= 1'b1;
          else                r_cnt[i] <= r_cnt[i] - PEND_W'(1);
        end
      end
    end
  end

endmodule
